avalon_pio_ctrl: RTL and testbench

Parametrised Avalon-MM slave general-purpose I/O block; next generation of the single-bit reset PIO used by the HPS–FPGA bridge to drive coprocessor control lines. It provides a WIDTH-bit output register with atomic set/clear, a self-timing pulse generator for reset/start strobes, and a synchronised input port. Optional rising/falling edge capture raises an interrupt.

---
 rtl/avalon_pio_pkg.sv | 18 +
 rtl/pio_sync_edge.sv | 32 +++
 rtl/avalon_pio_ctrl.sv | 106 ++++++++++
 tb/tb_avalon_pio_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg: register map, edge-mode encodings and counter sizing shared by the PIO block.
package avalon_pio_pkg;
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_SET      = 3'd2;
    localparam logic [2:0] ADDR_CLR      = 3'd3;
    localparam logic [2:0] ADDR_PULSE    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: two-flop input synchroniser followed by a one-cycle-delayed copy for edge detection.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edges
);
    logic [WIDTH-1:0] sync1, sync2, in_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            in_prev <= '0;
        end else begin
            sync1   <= in_port;
            sync2   <= sync1;
            in_prev <= sync2;
        end
    end

    assign in_sync = sync2;
    assign edges   = EDGE_MODE == EDGE_FALL ? (~sync2 & in_prev) :
                     EDGE_MODE == EDGE_BOTH ? (sync2 ^ in_prev) :
                                              (sync2 & ~in_prev);
endmodule

// File: rtl/avalon_pio_ctrl.sv
// avalon_pio_ctrl: Avalon-MM PIO with set/clear output register, self-timed pulses and synchronised inputs.
// Define PIO_EDGE_IRQ_EN to add edge capture with a masked level interrupt.
module avalon_pio_ctrl
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 16,
    parameter int               EDGE_MODE    = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int CW = cnt_width(PULSE_CYCLES);

    logic             wr, pulse_wr, unused_bits;
    logic [WIDTH-1:0] wdata, data_out, pulse_mask, in_sync, edges;
    logic [CW-1:0]    cnt;

    assign wr       = chipselect & ~write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign pulse_wr = wr && address == ADDR_PULSE && |wdata;
    assign out_port = data_out | pulse_mask;

    pio_sync_edge #(.WIDTH(WIDTH), .EDGE_MODE(EDGE_MODE)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .in_sync (in_sync),
        .edges   (edges)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            data_out <= RESET_VALUE;
        else if (wr)
            data_out <= address == ADDR_DATA ? wdata :
                        address == ADDR_SET  ? data_out | wdata :
                        address == ADDR_CLR  ? data_out & ~wdata : data_out;
    end

    // One shared counter: any retrigger restarts the full width for every active bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            pulse_mask <= '0;
        end else if (pulse_wr) begin
            cnt        <= CW'(PULSE_CYCLES);
            pulse_mask <= pulse_mask | wdata;
        end else if (cnt == CW'(1)) begin
            cnt        <= '0;
            pulse_mask <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] irq_mask, edge_cap, mask_nxt, cap_nxt;

    assign unused_bits = ^writedata;

    // New edges are ORed in after the clear so a coincident edge survives its W1C.
    always_comb begin
        mask_nxt = (wr && address == ADDR_IRQ_MASK) ? wdata : irq_mask;
        cap_nxt  = (edge_cap & ~((wr && address == ADDR_EDGE_CAP) ? wdata : '0)) | edges;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            irq_mask <= mask_nxt;
            edge_cap <= cap_nxt;
            irq      <= |(cap_nxt & mask_nxt);
        end
    end
`else
    assign unused_bits = ^{writedata, edges};
    assign irq         = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = in_sync;
            ADDR_OUT:      readdata[WIDTH-1:0] = data_out;
            ADDR_PULSE:    readdata[WIDTH-1:0] = pulse_mask;
`ifdef PIO_EDGE_IRQ_EN
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
`endif
            default:       readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// tb_avalon_pio_ctrl: directed vector table plus hand sequences for pulses, reset, sync latency and edge IRQ.
module tb_avalon_pio_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [7:0]  in_port = '0;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    avalon_pio_ctrl #(.WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(16), .EDGE_MODE(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];
    int   b0, b1;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0F,  3'd1, 8'h0F, 32'h0F};
        vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h30,  3'd1, 8'h3F, 32'h3F};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 32'h05,  3'd1, 8'h3A, 32'h3A};
        vecs[3]  = '{1'b1, 1'b1, 3'd0, 32'hFF,  3'd0, 8'h3A, 32'h00};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 32'hFF,  3'd1, 8'h3A, 32'h3A};
        vecs[5]  = '{1'b1, 1'b0, 3'd7, 32'hFF,  3'd7, 8'h3A, 32'h00};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 32'h00,  3'd1, 8'h3A, 32'h3A};
        vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'h1FF, 3'd1, 8'hFF, 32'hFF};
        vecs[8]  = '{1'b1, 1'b0, 3'd3, 32'hF0,  3'd1, 8'h0F, 32'h0F};
        vecs[9]  = '{1'b1, 1'b0, 3'd2, 32'h00,  3'd4, 8'h0F, 32'h00};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 32'h00,  3'd1, 8'h00, 32'h00};

        tick(2);
        chk("rst_out", {24'h0, out_port}, 32'hA5);
        rd_chk("rst_rd_out", 3'd1, 32'hA5);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(1);
        chk("post_rst_out", {24'h0, out_port}, 32'hA5);
        rd_chk("post_rst_pulse", 3'd4, 32'h0);

        for (int i = 0; i < 11; i++) begin
            chipselect = vecs[i].cs;
            write_n = vecs[i].wn;
            address = vecs[i].addr;
            writedata = vecs[i].wdata;
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n = 1'b1;
            address = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
        end

        // Pulse on bit0, retrigger with bit1 in cycle 10.
        wr(3'd4, 32'h01);
        b0 = 0;
        b1 = 0;
        for (int c = 1; c <= 30; c++) begin
            if (out_port[0]) b0++;
            if (out_port[1]) b1++;
            if (c == 12) chk("pulse_mask_rd", readdata, 32'h03);
            if (c == 26) chk("pulse_last", {24'h0, out_port}, 32'h03);
            if (c == 27) chk("pulse_done", {24'h0, out_port}, 32'h00);
            if (c == 10) begin
                writedata = 32'h02;
                chipselect = 1'b1;
                write_n = 1'b0;
            end
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n = 1'b1;
        end
        chk("pulse_bit0_len", b0, 26);
        chk("pulse_bit1_len", b1, 16);
        wr(3'd4, 32'h00);
        chk("pulse_zero_out", {24'h0, out_port}, 32'h00);
        rd_chk("pulse_zero_rd", 3'd4, 32'h00);

        wr(3'd2, 32'h04);
        wr(3'd4, 32'h04);
        wr(3'd3, 32'h04);
        chk("clr_keeps_pulse", {24'h0, out_port}, 32'h04);
        wr(3'd2, 32'h08);
        wr(3'd4, 32'h08);
        tick(20);
        chk("set_and_pulse", {24'h0, out_port}, 32'h08);

        wr(3'd4, 32'hF0);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out", {24'h0, out_port}, 32'hA5);
        rd_chk("midrst_rd", 3'd1, 32'hA5);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1);
        rd_chk("midrst_pulse", 3'd4, 32'h00);

        in_port = 8'h81;
        rd_chk("sync_c1", 3'd0, 32'h00);
        tick(1);
        rd_chk("sync_c2", 3'd0, 32'h00);
        tick(1);
        rd_chk("sync_c3", 3'd0, 32'h81);
        in_port = 8'h00;
        tick(4);

`ifdef PIO_EDGE_IRQ_EN
        wr(3'd6, 32'hFF);
        rd_chk("cap_cleared", 3'd6, 32'h00);
        chk("irq_idle", {31'h0, irq}, 32'h0);
        wr(3'd5, 32'h01);
        rd_chk("mask_rd", 3'd5, 32'h01);
        in_port = 8'h01;
        tick(2);
        chk("irq_before_edge", {31'h0, irq}, 32'h0);
        tick(1);
        rd_chk("cap_rise", 3'd6, 32'h01);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        in_port = 8'h00;
        tick(3);
        chk("irq_no_fall", {31'h0, irq}, 32'h1);
        in_port = 8'h01;
        tick(2);
        wr(3'd6, 32'h01);
        rd_chk("cap_set_wins", 3'd6, 32'h01);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        wr(3'd6, 32'h01);
        chk("irq_w1c", {31'h0, irq}, 32'h0);
        rd_chk("cap_w1c", 3'd6, 32'h00);
`else
        wr(3'd5, 32'hFF);
        wr(3'd6, 32'hFF);
        rd_chk("noirq_rd5", 3'd5, 32'h00);
        rd_chk("noirq_rd6", 3'd6, 32'h00);
        chk("noirq_irq", {31'h0, irq}, 32'h0);
        chk("noirq_out", {24'h0, out_port}, 32'hA5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
